mem_arbiter: RTL and testbench

Two-requester memory arbiter between the CPU pipeline and the single external memory port of `cpu`. It takes instruction fetches from `if_stage` and data reads and writes from the memory stage and grants one transaction at a time. It drives `mem_read`/`mem_write`/`mem_addr`/`mem_write_data`, holds them until `mem_ack`, then returns the registered read data to the winning requester with a one-cycle acknowledge pulse.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arbiter_arb_select.sv | 43 ++++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arb_pkg                                                  |
// | Description : Shared types and constants for the two-port memory arbiter: |
// |               FSM state enum, owner encoding and default bus widths.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  // Owner of the current transaction. The same encoding is used for the
  // round-robin pointer, where it names the port that has priority next.
  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_arb_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arb_select                                                   |
// | Description : Combinational grant selection between the instruction and   |
// |               data ports.                                                  |
// |               Fixed priority (default): data port wins.                    |
// |               MEM_ARB_ROUND_ROBIN_EN defined: on contention the port named |
// |               by rr_ptr_i wins.                                            |
// | Ports       : ic_req_i, dc_req_i  - port request lines                     |
// |               rr_ptr_i            - port with priority (round-robin only)  |
// |               grant_valid_o       - at least one request present           |
// |               grant_owner_o       - winning port (OWNER_IC / OWNER_DC)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module arb_select
  import mem_arb_pkg::*;
(
  input  logic ic_req_i,
  input  logic dc_req_i,
  input  logic rr_ptr_i,
  output logic grant_valid_o,
  output logic grant_owner_o
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority has no use for the pointer.
  logic w_unused_ptr;
  assign w_unused_ptr = rr_ptr_i;
`endif

  always_comb begin
    grant_valid_o = ic_req_i | dc_req_i;
    grant_owner_o = dc_req_i ? OWNER_DC : OWNER_IC;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // A lone requester always wins; the pointer only breaks ties.
    if (ic_req_i && dc_req_i) begin
      grant_owner_o = rr_ptr_i;
    end
`endif
  end

endmodule : arb_select
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Two-requester arbiter in front of a single external memory  |
// |               port. Grants one transaction at a time (IDLE/BUSY/RESP),    |
// |               holds the mem_* strobe until mem_ack, then returns the read |
// |               data with a one-cycle ack to the winning port.              |
// |               Configuration macro: MEM_ARB_ROUND_ROBIN_EN selects          |
// |               round-robin instead of fixed data-over-instruction priority.|
// | Ports       : clk, reset (sync, active-high)                               |
// |               ic_*  - instruction fetch port (read only)                   |
// |               dc_*  - data port (read / write)                             |
// |               mem_* - external memory port                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_read_req,
  input  logic [ADDR_WIDTH-1:0] ic_read_addr,
  output logic                  ic_read_ack,
  output logic [DATA_WIDTH-1:0] ic_read_data,
  input  logic                  dc_read_req,
  input  logic                  dc_write_req,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [DATA_WIDTH-1:0] dc_write_data,
  output logic                  dc_ack,
  output logic [DATA_WIDTH-1:0] dc_read_data,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [DATA_WIDTH-1:0] mem_write_data
);

  state_e                state_q,     state_d;
  logic                  owner_q,     owner_d;
  logic                  mem_read_q,  mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  ic_ack_q,    ic_ack_d;
  logic [DATA_WIDTH-1:0] ic_rdata_q,  ic_rdata_d;
  logic                  dc_ack_q,    dc_ack_d;
  logic [DATA_WIDTH-1:0] dc_rdata_q,  dc_rdata_d;

  logic w_rr_ptr;
  logic w_grant_valid;
  logic w_grant_owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Names the port that wins the next tie; starts on the data port.
  logic rr_ptr_q, rr_ptr_d;
  assign w_rr_ptr = rr_ptr_q;
`else
  assign w_rr_ptr = OWNER_DC;
`endif

  arb_select u_arb_select (
    .ic_req_i      (ic_read_req),
    .dc_req_i      (dc_read_req | dc_write_req),
    .rr_ptr_i      (w_rr_ptr),
    .grant_valid_o (w_grant_valid),
    .grant_owner_o (w_grant_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    // Acks are only ever high in RESP, which lasts one cycle.
    ic_ack_d    = 1'b0;
    dc_ack_d    = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    case (state_q)
      IDLE: begin
        if (w_grant_valid) begin
          owner_d = w_grant_owner;
          state_d = BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_ptr_d = ~w_grant_owner;
`endif
          if (w_grant_owner == OWNER_DC) begin
            mem_addr_d  = dc_addr;
            // A combined read+write request is served as a write.
            mem_write_d = dc_write_req;
            mem_read_d  = ~dc_write_req;
            if (dc_write_req) begin
              mem_wdata_d = dc_write_data;
            end
          end else begin
            mem_addr_d  = ic_read_addr;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
          end
        end
      end

      BUSY: begin
        if (mem_ack) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESP;
          if (owner_q == OWNER_DC) begin
            dc_ack_d = 1'b1;
            // A write leaves the previous load data visible.
            if (!mem_write_q) begin
              dc_rdata_d = mem_read_data;
            end
          end else begin
            ic_ack_d   = 1'b1;
            ic_rdata_d = mem_read_data;
          end
        end
      end

      RESP: begin
        // Requests are not sampled here, so a held request is not re-granted.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_IC;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_ack_q    <= 1'b0;
      ic_rdata_q  <= '0;
      dc_ack_q    <= 1'b0;
      dc_rdata_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= OWNER_DC;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_ack_q    <= ic_ack_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_ack_q    <= dc_ack_d;
      dc_rdata_q  <= dc_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign ic_read_ack    = ic_ack_q;
  assign ic_read_data   = ic_rdata_q;
  assign dc_ack         = dc_ack_q;
  assign dc_read_data   = dc_rdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Scoreboard bench for mem_arbiter. Directed requests push the|
// |               expected memory transactions and acks into queues; a memory |
// |               model and an ack monitor pop and compare independently.     |
// |               Honours MEM_ARB_ROUND_ROBIN_EN for the grant-order cases.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_read_req;
  logic [31:0] ic_read_addr;
  logic        ic_read_ack;
  logic [31:0] ic_read_data;
  logic        dc_read_req;
  logic        dc_write_req;
  logic [31:0] dc_addr;
  logic [31:0] dc_write_data;
  logic        dc_ack;
  logic [31:0] dc_read_data;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_read_data;
  logic [31:0] mem_write_data;

  logic model_ack;
  logic manual_ack;
  assign mem_ack = model_ack | manual_ack;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ic_read_req    (ic_read_req),
    .ic_read_addr   (ic_read_addr),
    .ic_read_ack    (ic_read_ack),
    .ic_read_data   (ic_read_data),
    .dc_read_req    (dc_read_req),
    .dc_write_req   (dc_write_req),
    .dc_addr        (dc_addr),
    .dc_write_data  (dc_write_data),
    .dc_ack         (dc_ack),
    .dc_read_data   (dc_read_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_ack        (mem_ack),
    .mem_addr       (mem_addr),
    .mem_read_data  (mem_read_data),
    .mem_write_data (mem_write_data)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mem_t;

  typedef struct {
    logic        is_dc;
    logic [31:0] data;
  } rsp_t;

  mem_t exp_mem[$];
  rsp_t exp_rsp[$];
  bit   mem_model_en = 1'b1;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd);
    mem_t m;
    m.wr = wr; m.addr = a; m.wdata = wd; m.rdata = rd;
    exp_mem.push_back(m);
  endtask

  task automatic push_rsp(input logic is_dc, input logic [31:0] d);
    rsp_t r;
    r.is_dc = is_dc; r.data = d;
    exp_rsp.push_back(r);
  endtask

  // Memory model: acks two cycles after it first sees a strobe.
  initial begin
    mem_t m;
    model_ack     = 1'b0;
    mem_read_data = 32'h0BAD_0BAD;
    forever begin
      @(negedge clk);
      if (mem_model_en && !reset && (mem_read || mem_write)) begin
        if (exp_mem.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected: got wr=%b addr=%h expected no access", mem_write, mem_addr);
          m.wr = mem_write; m.addr = mem_addr; m.wdata = mem_write_data; m.rdata = 32'h0BAD_0BAD;
        end else begin
          m = exp_mem.pop_front();
        end
        check("mem_write", {31'b0, mem_write}, {31'b0, m.wr});
        check("mem_read", {31'b0, mem_read}, {31'b0, ~m.wr});
        check("mem_addr", mem_addr, m.addr);
        if (m.wr) check("mem_wdata", mem_write_data, m.wdata);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mem_strobe_held", {31'b0, mem_read | mem_write}, 32'd1);
        check("mem_addr_stable", mem_addr, m.addr);
        if (m.wr) check("mem_wdata_stable", mem_write_data, m.wdata);
        model_ack     = 1'b1;
        mem_read_data = m.rdata;
        @(posedge clk);
        #1;
        model_ack     = 1'b0;
        mem_read_data = 32'h0BAD_0BAD;
      end
    end
  end

  // Ack monitor: every ack must match the head of the response queue.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (ic_read_ack || dc_ack) begin
        if (ic_read_ack && dc_ack) begin
          total++; bad++;
          $display("FAIL ack_both: got ic=1 dc=1 expected one ack");
        end
        if (exp_rsp.size() == 0) begin
          total++; bad++;
          $display("FAIL ack_unexpected: got ic=%b dc=%b expected none", ic_read_ack, dc_ack);
        end else begin
          r = exp_rsp.pop_front();
          check("ack_port_dc", {31'b0, dc_ack}, {31'b0, r.is_dc});
          check("ack_data", r.is_dc ? dc_read_data : ic_read_data, r.data);
        end
      end
    end
  end

  task automatic ic_fetch(input logic [31:0] a);
    int n;
    ic_read_req  = 1'b1;
    ic_read_addr = a;
    n = 0;
    forever begin
      @(negedge clk);
      if (ic_read_ack) break;
      n++;
      if (n > 100) begin
        total++; bad++;
        $display("FAIL ic_timeout: got no ic_read_ack expected one for addr %h", a);
        break;
      end
    end
    @(posedge clk);
    #1;
    ic_read_req  = 1'b0;
    ic_read_addr = 32'hFFFF_FFF0;
  endtask

  task automatic dc_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd);
    int n;
    dc_read_req   = rd;
    dc_write_req  = wr;
    dc_addr       = a;
    dc_write_data = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (dc_ack) break;
      n++;
      if (n > 100) begin
        total++; bad++;
        $display("FAIL dc_timeout: got no dc_ack expected one for addr %h", a);
        break;
      end
    end
    @(posedge clk);
    #1;
    dc_read_req   = 1'b0;
    dc_write_req  = 1'b0;
    dc_addr       = 32'hEEEE_EEE0;
    dc_write_data = 32'hEEEE_EEEE;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_read"},  {31'b0, mem_read},    32'd0);
    check({tag, "_mem_write"}, {31'b0, mem_write},   32'd0);
    check({tag, "_ic_ack"},    {31'b0, ic_read_ack}, 32'd0);
    check({tag, "_dc_ack"},    {31'b0, dc_ack},      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset         = 1'b1;
    manual_ack    = 1'b0;
    ic_read_req   = 1'b0;
    ic_read_addr  = '0;
    dc_read_req   = 1'b0;
    dc_write_req  = 1'b0;
    dc_addr       = '0;
    dc_write_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_all_zero("rst");
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);
    check("rst_ic_data", ic_read_data, 32'h0);
    check("rst_dc_data", dc_read_data, 32'h0);
    @(posedge clk);
    #1;

    // Fetch
    push_mem(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF);
    push_rsp(1'b0, 32'hDEAD_BEEF);
    ic_fetch(32'h0000_0040);

    // Data read, so the following store has visible prior load data
    push_mem(1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_0001);
    push_rsp(1'b1, 32'hCAFE_0001);
    dc_access(1'b1, 1'b0, 32'h0000_0200, 32'h0);

    // Store: dc_read_data keeps the previous load value
    push_mem(1'b1, 32'h0000_0100, 32'h1234_5678, 32'h5555_AAAA);
    push_rsp(1'b1, 32'hCAFE_0001);
    dc_access(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678);

    // Read and write together: served as a write
    push_mem(1'b1, 32'h0000_0300, 32'h0000_A5A5, 32'h7777_7777);
    push_rsp(1'b1, 32'hCAFE_0001);
    dc_access(1'b1, 1'b1, 32'h0000_0300, 32'h0000_A5A5);

    // Contention in the same cycle
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Last three grants went to the data port, so the fetch wins the tie.
    push_mem(1'b0, 32'h0000_0044, 32'h0, 32'h2222_0000);
    push_rsp(1'b0, 32'h2222_0000);
    push_mem(1'b0, 32'h0000_0400, 32'h0, 32'h1111_0000);
    push_rsp(1'b1, 32'h1111_0000);
`else
    push_mem(1'b0, 32'h0000_0400, 32'h0, 32'h1111_0000);
    push_rsp(1'b1, 32'h1111_0000);
    push_mem(1'b0, 32'h0000_0044, 32'h0, 32'h2222_0000);
    push_rsp(1'b0, 32'h2222_0000);
`endif
    fork
      ic_fetch(32'h0000_0044);
      dc_access(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    join

    // Lone fetch: always granted immediately; leaves the data port next in line
    push_mem(1'b0, 32'h0000_0048, 32'h0, 32'h3333_0048);
    push_rsp(1'b0, 32'h3333_0048);
    ic_fetch(32'h0000_0048);

    // Both ports requesting back-to-back for four transactions
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_mem(1'b0, 32'h0000_0500, 32'h0, 32'h5555_0000); push_rsp(1'b1, 32'h5555_0000);
    push_mem(1'b0, 32'h0000_0080, 32'h0, 32'h6666_0080); push_rsp(1'b0, 32'h6666_0080);
    push_mem(1'b0, 32'h0000_0504, 32'h0, 32'h5555_0004); push_rsp(1'b1, 32'h5555_0004);
    push_mem(1'b0, 32'h0000_0084, 32'h0, 32'h6666_0084); push_rsp(1'b0, 32'h6666_0084);
`else
    push_mem(1'b0, 32'h0000_0500, 32'h0, 32'h5555_0000); push_rsp(1'b1, 32'h5555_0000);
    push_mem(1'b0, 32'h0000_0504, 32'h0, 32'h5555_0004); push_rsp(1'b1, 32'h5555_0004);
    push_mem(1'b0, 32'h0000_0080, 32'h0, 32'h6666_0080); push_rsp(1'b0, 32'h6666_0080);
    push_mem(1'b0, 32'h0000_0084, 32'h0, 32'h6666_0084); push_rsp(1'b0, 32'h6666_0084);
`endif
    fork
      begin
        dc_access(1'b1, 1'b0, 32'h0000_0500, 32'h0);
        dc_access(1'b1, 1'b0, 32'h0000_0504, 32'h0);
      end
      begin
        ic_fetch(32'h0000_0080);
        ic_fetch(32'h0000_0084);
      end
    join

    // Reset while BUSY, then a late mem_ack
    mem_model_en = 1'b0;
    dc_read_req  = 1'b1;
    dc_addr      = 32'h0000_0600;
    n = 0;
    while (!mem_read && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("busy_strobe", {31'b0, mem_read}, 32'd1);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    dc_read_req = 1'b0;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    manual_ack = 1'b1;
    @(negedge clk);
    check_all_zero("busy_rst");
    check("busy_rst_dc_data", dc_read_data, 32'h0);
    check("busy_rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1;
    manual_ack = 1'b0;
    @(negedge clk);
    check_all_zero("late_ack");
    @(negedge clk);
    check_all_zero("late_ack2");

    // Stray ack in IDLE
    @(posedge clk);
    #1;
    manual_ack = 1'b1;
    @(negedge clk);
    check_all_zero("stray");
    @(posedge clk);
    #1;
    manual_ack = 1'b0;
    @(negedge clk);
    check_all_zero("stray2");
    @(negedge clk);
    check_all_zero("stray3");
    mem_model_en = 1'b1;

    // Arbiter still serves normally afterwards
    push_mem(1'b0, 32'h0000_00C0, 32'h0, 32'h3C3C_3C3C);
    push_rsp(1'b0, 32'h3C3C_3C3C);
    ic_fetch(32'h0000_00C0);

    n = 0;
    while ((exp_mem.size() != 0 || exp_rsp.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("exp_mem_drained", exp_mem.size(), 32'd0);
    check("exp_rsp_drained", exp_rsp.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
